sysid_check_master: RTL and testbench

- Small Avalon-MM read master that sits directly upstream of the system-ID slave.
- Drives the slave's 1-bit address and consumes its 32-bit readdata.
- Flow: on a start pulse it reads the ID word (address 0), then the timestamp word (address 1), and compares both against compile-time expected values.
- Publishes captured words plus match/done flags to boot/status logic, so a mismatched FPGA image is detected before software runs.

---
 rtl/sysid_check_master.sv | 153 +++++++++++++++
 tb/tb_sysid_check_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that checks the system-ID slave against expected words.
// Optional retry on mismatch: define SYSID_CHECK_RETRY_EN.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'hDEADBEEF,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5B91FC55,
    parameter int unsigned READ_LATENCY       = 1,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        pass,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic [3:0]  retry_q, retry_d;
    logic        cmp_ok;

    assign cmp_ok = (id_value_q == EXPECTED_ID) &&
                    (ts_value_q == EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECK_RETRY_EN
    localparam logic [3:0] MAXR = 4'(MAX_RETRIES);
`else
    // MAX_RETRIES has no effect without the retry feature.
    logic unused_max_retries;
    assign unused_max_retries = ^4'(MAX_RETRIES);
`endif

    // Next-state and capture logic for the read/compare sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        id_match_d = id_match_q;
        ts_match_d = ts_match_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        retry_d    = retry_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_ID;
                    done_d     = 1'b0;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                    retry_d    = 4'd0;
                    cnt_d      = 3'd0;
                end
            end
            RD_ID: begin
                if (cnt_q == LAT) begin
                    id_value_d = sysid_readdata;
                    cnt_d      = 3'd0;
                    state_d    = RD_TS;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD_TS: begin
                if (cnt_q == LAT) begin
                    ts_value_d = sysid_readdata;
                    cnt_d      = 3'd0;
                    state_d    = CMP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            CMP: begin
                id_match_d = (id_value_q == EXPECTED_ID);
                ts_match_d = (ts_value_q == EXPECTED_TIMESTAMP);
`ifdef SYSID_CHECK_RETRY_EN
                if (!cmp_ok && (retry_q < MAXR)) begin
                    retry_d = retry_q + 4'd1;
                    cnt_d   = 3'd0;
                    state_d = RD_ID;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                done_d  = 1'b1;
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset clears everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            id_match_q <= 1'b0;
            ts_match_q <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
            retry_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            id_match_q <= id_match_d;
            ts_match_q <= ts_match_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            retry_q    <= retry_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign sysid_read    = (state_q == RD_ID) || (state_q == RD_TS);
    assign sysid_address = (state_q == RD_TS);
    assign done          = done_q;
    assign id_match      = id_match_q;
    assign ts_match      = ts_match_q;
    assign pass          = done_q & id_match_q & ts_match_q;
    assign id_value      = id_value_q;
    assign ts_value      = ts_value_q;
`ifdef SYSID_CHECK_RETRY_EN
    assign retry_count   = retry_q;
`else
    assign retry_count   = 4'd0;
`endif

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: three instances at read latency 1, 0 and 3,
// each fed by a slave model whose data is valid only after the latency.
module tb_sysid_check_master;

    localparam logic [31:0] EID  = 32'hDEADBEEF;
    localparam logic [31:0] ETS  = 32'h5B91FC55;
    localparam int          MAXR = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic        st    [3];
    logic        addr  [3];
    logic        rd    [3];
    logic [31:0] rdata [3];
    logic        bsy   [3];
    logic        dn    [3];
    logic        idm   [3];
    logic        tsm   [3];
    logic        ps    [3];
    logic [31:0] idv   [3];
    logic [31:0] tsv   [3];
    logic [3:0]  rc    [3];

    logic [31:0] w0 [3][4];
    logic [31:0] w1 [3][4];
    int          base   [3];
    int          passes [3] = '{0, 0, 0};
    logic        prd    [3] = '{0, 0, 0};
    logic        pad    [3] = '{0, 0, 0};
    int          cc     [3] = '{0, 0, 0};
    int          cur    [3];

    int ncmp = 0;
    int nfail = 0;

    sysid_check_master #(.READ_LATENCY(1)) u0 (
        .clock(clock), .reset_n(reset_n), .start(st[0]),
        .sysid_address(addr[0]), .sysid_read(rd[0]),
        .sysid_readdata(rdata[0]), .busy(bsy[0]), .done(dn[0]),
        .id_match(idm[0]), .ts_match(tsm[0]), .pass(ps[0]),
        .id_value(idv[0]), .ts_value(tsv[0]), .retry_count(rc[0]));

    sysid_check_master #(.READ_LATENCY(0)) u1 (
        .clock(clock), .reset_n(reset_n), .start(st[1]),
        .sysid_address(addr[1]), .sysid_read(rd[1]),
        .sysid_readdata(rdata[1]), .busy(bsy[1]), .done(dn[1]),
        .id_match(idm[1]), .ts_match(tsm[1]), .pass(ps[1]),
        .id_value(idv[1]), .ts_value(tsv[1]), .retry_count(rc[1]));

    sysid_check_master #(.READ_LATENCY(3)) u2 (
        .clock(clock), .reset_n(reset_n), .start(st[2]),
        .sysid_address(addr[2]), .sysid_read(rd[2]),
        .sysid_readdata(rdata[2]), .busy(bsy[2]), .done(dn[2]),
        .id_match(idm[2]), .ts_match(tsm[2]), .pass(ps[2]),
        .id_value(idv[2]), .ts_value(tsv[2]), .retry_count(rc[2]));

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    // Slave model: word valid only once the same address was held L cycles.
    always_comb begin
        for (int g = 0; g < 3; g++) begin
            int pi;
            cur[g] = (prd[g] && rd[g] && (pad[g] == addr[g])) ? cc[g] + 1 : 0;
            pi = passes[g] - base[g];
            if (pi > 3) pi = 3;
            if (pi < 0) pi = 0;
            if (rd[g] && cur[g] >= lat_of(g))
                rdata[g] = addr[g] ? w1[g][pi] : w0[g][pi];
            else
                rdata[g] = 32'hBAD0BAD0;
        end
    end

    always @(posedge clock) begin
        for (int g = 0; g < 3; g++) begin
            prd[g] <= rd[g];
            pad[g] <= addr[g];
            cc[g]  <= cur[g];
            if (prd[g] && !rd[g]) passes[g] <= passes[g] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk({tag, " busy"}, 32'(bsy[g]), 0);
        chk({tag, " done"}, 32'(dn[g]), 0);
        chk({tag, " idm"}, 32'(idm[g]), 0);
        chk({tag, " tsm"}, 32'(tsm[g]), 0);
        chk({tag, " pass"}, 32'(ps[g]), 0);
        chk({tag, " idv"}, idv[g], 0);
        chk({tag, " tsv"}, tsv[g], 0);
        chk({tag, " rc"}, 32'(rc[g]), 0);
        chk({tag, " addr"}, 32'(addr[g]), 0);
        chk({tag, " read"}, 32'(rd[g]), 0);
    endtask

    // One check on instance g; rep=1 re-pulses start in RD_TS, rep=2 in CMP.
    task automatic run(input int g, input logic [31:0] a0 [4],
                       input logic [31:0] a1 [4], input int rep,
                       input string tag);
        int L, n, expcyc, cnt, c0, c1;
        bit first_done, busy_bad;
        L = lat_of(g);
        n = 1;
`ifdef SYSID_CHECK_RETRY_EN
        for (int k = 0; k <= MAXR; k++) begin
            n = k + 1;
            if (a0[k] == EID && a1[k] == ETS) break;
        end
`endif
        expcyc = n * (2 * (L + 1) + 1);
        for (int k = 0; k < 4; k++) begin
            w0[g][k] = a0[k];
            w1[g][k] = a1[k];
        end
        @(negedge clock);
        base[g] = passes[g];
        st[g] = 1'b1;
        @(negedge clock);
        cnt = 0; c0 = 0; c1 = 0;
        first_done = 0; busy_bad = 0;
        forever begin
            st[g] = 1'b0;
            if (!first_done) begin
                if (rd[g]) begin
                    if (addr[g]) c1++;
                    else c0++;
                end else if (c0 + c1 > 0) begin
                    first_done = 1;
                end
            end
            if (rep == 1 && cnt == L + 1) st[g] = 1'b1;
            if (rep == 2 && cnt == 2 * L + 2) st[g] = 1'b1;
            if (cnt < expcyc && !bsy[g]) busy_bad = 1;
            if (dn[g] || cnt >= expcyc + 8) break;
            @(negedge clock);
            cnt++;
        end
        st[g] = 1'b0;
        chk({tag, " latency"}, cnt, expcyc);
        chk({tag, " done"}, 32'(dn[g]), 1);
        chk({tag, " busy_gap"}, 32'(busy_bad), 0);
        chk({tag, " busy_end"}, 32'(bsy[g]), 0);
        chk({tag, " addr0_cycles"}, c0, L + 1);
        chk({tag, " addr1_cycles"}, c1, L + 1);
        chk({tag, " id_value"}, idv[g], a0[n-1]);
        chk({tag, " ts_value"}, tsv[g], a1[n-1]);
        chk({tag, " id_match"}, 32'(idm[g]), 32'(a0[n-1] == EID));
        chk({tag, " ts_match"}, 32'(tsm[g]), 32'(a1[n-1] == ETS));
        chk({tag, " pass"}, 32'(ps[g]),
            32'(a0[n-1] == EID && a1[n-1] == ETS));
        chk({tag, " retry"}, 32'(rc[g]), n - 1);
        repeat (2) @(negedge clock);
        chk({tag, " idle_hold"}, 32'({bsy[g], dn[g]}), 32'b01);
    endtask

    typedef struct {
        int          g;
        logic [31:0] id;
        logic [31:0] ts;
        int          rep;
        logic        e_idm;
        logic        e_tsm;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tab [8];
        logic [31:0] a0 [4];
        logic [31:0] a1 [4];

        tab[0] = '{0, EID, ETS, 0, 1'b1, 1'b1};
        tab[1] = '{0, 32'h0, ETS, 0, 1'b0, 1'b1};
        tab[2] = '{0, EID, 32'h0, 1, 1'b1, 1'b0};
        tab[3] = '{1, EID, ETS, 0, 1'b1, 1'b1};
        tab[4] = '{2, EID, ETS, 2, 1'b1, 1'b1};
        tab[5] = '{2, EID ^ 32'h1, ETS ^ 32'h80000000, 0, 1'b0, 1'b0};
        tab[6] = '{1, 32'hDEADBEEE, ETS, 1, 1'b0, 1'b1};
        tab[7] = '{0, EID, ETS, 2, 1'b1, 1'b1};

        for (int g = 0; g < 3; g++) begin
            st[g] = 1'b0;
            base[g] = 0;
            for (int k = 0; k < 4; k++) begin
                w0[g][k] = 32'h0;
                w1[g][k] = 32'h0;
            end
        end

        #1;
        chk_zero(0, "reset_u0");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_zero(1, "after_reset_u1");
        chk_zero(2, "after_reset_u2");

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) begin
                a0[k] = tab[i].id;
                a1[k] = tab[i].ts;
            end
            run(tab[i].g, a0, a1, tab[i].rep, $sformatf("tab%0d", i));
            chk($sformatf("tab%0d idm_tab", i), 32'(idm[tab[i].g]),
                32'(tab[i].e_idm));
            chk($sformatf("tab%0d tsm_tab", i), 32'(tsm[tab[i].g]),
                32'(tab[i].e_tsm));
        end

        a0 = '{32'h0, 32'h1, EID, EID};
        a1 = '{ETS, 32'h0, ETS, ETS};
        run(0, a0, a1, 0, "match_third");
        a0 = '{32'h0, 32'h0, 32'h0, 32'h0};
        a1 = '{ETS, ETS, ETS, ETS};
        run(0, a0, a1, 0, "persist_bad");
        a0 = '{EID, 32'h7, EID, EID};
        a1 = '{32'h5, ETS, ETS, ETS};
        run(2, a0, a1, 0, "match_second_l3");

        // Reset during RD_ID aborts with everything cleared.
        @(negedge clock);
        st[0] = 1'b1;
        @(negedge clock);
        st[0] = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk_zero(0, "mid_reset");
        @(negedge clock);
        reset_n = 1'b1;
        a0 = '{EID, EID, EID, EID};
        a1 = '{ETS, ETS, ETS, ETS};
        run(0, a0, a1, 0, "post_reset");

        for (int i = 0; i < 24; i++) begin
            int g;
            g = $urandom_range(0, 2);
            for (int k = 0; k < 4; k++) begin
                a0[k] = ($urandom_range(0, 1) == 1) ? EID : $urandom;
                a1[k] = ($urandom_range(0, 1) == 1) ? ETS : $urandom;
            end
            run(g, a0, a1, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
